// File: rtl/alu_md_if.sv
// Request/response bundle between the operand muxes, the ALU/MD unit and writeback.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_md_iter.sv
// RV32I ALU plus RV32M multiply/divide. Base ops and the divide corner cases
// finish in one cycle; other M ops iterate one bit per cycle on a shared
// shift-add multiplier / restoring divider datapath.
module alu_md_iter #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_md_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;       // partial product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;       // multiplier bits / dividend bits -> quotient
  logic [XLEN-1:0] opr_q, opr_d;     // |data2|: multiplicand or divisor
  logic [2:0]      mop_q, mop_d;
  logic            neg_q, neg_d;     // negate product / quotient
  logic            rneg_q, rneg_d;   // negate remainder
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] a, b;
  logic [2:0]      op3;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, fast;
  logic [XLEN:0]   sum, shl, diff;
  logic [XLEN-1:0] step_hi, step_lo;

  function automatic logic [XLEN-1:0] f_base(input logic [3:0] fn,
                                             input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs, ys;
    logic [SHW-1:0]         sh;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    case (fn)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x << sh;
      4'd3:    return {{(XLEN-1){1'b0}}, xs < ys};
      4'd4:    return {{(XLEN-1){1'b0}}, x < y};
      4'd5:    return x ^ y;
      4'd6:    return x >> sh;
      4'd7:    return xs >>> sh;
      4'd8:    return x | y;
      4'd9:    return x & y;
      4'd10:   return y;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Divide-by-zero and most-negative / -1 results, which skip iteration.
  function automatic logic [XLEN-1:0] f_fast_md(input logic is_rem, input logic zero,
                                                input logic [XLEN-1:0] x);
    if (zero) return is_rem ? x : '1;
    return is_rem ? '0 : x;
  endfunction

  // Sign correction and half/quotient/remainder selection after the last step.
  function automatic logic [XLEN-1:0] f_finish(input logic [2:0] mop, input logic neg,
                                               input logic rneg,
                                               input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    prod = {hi, lo};
    if (neg) prod = -prod;
    if (mop[2]) begin
      if (mop[1]) return rneg ? -hi : hi;
      return neg ? -lo : lo;
    end
    if (mop[1:0] == 2'b00) return prod[XLEN-1:0];
    return prod[2*XLEN-1:XLEN];
  endfunction

  assign a   = bus.data1;
  assign b   = bus.data2;
  assign op3 = bus.op[2:0];

  // Request decode: operand signedness, fast-path detection.
  always_comb begin
    a_sgn    = (op3 == 3'd1) || (op3 == 3'd2) || (op3 == 3'd4) || (op3 == 3'd6);
    b_sgn    = (op3 == 3'd1) || (op3 == 3'd4) || (op3 == 3'd6);
    a_neg    = a_sgn & a[XLEN-1];
    b_neg    = b_sgn & b[XLEN-1];
    div_zero = op3[2] & (b == '0);
    div_ovf  = op3[2] & ~op3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    fast     = ~bus.op[4] | div_zero | div_ovf;
  end

  // One multiply or divide bit per cycle on the shared registers.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : '0);
    shl  = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, opr_q};
    if (mop_q[2]) begin
      if (!diff[XLEN]) begin
        step_hi = diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = shl[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[XLEN:1];
      step_lo = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Next-state and datapath load/update decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opr_d    = opr_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (fast) begin
            result_d = bus.op[4] ? f_fast_md(op3[1], div_zero, a) : f_base(bus.op[3:0], a, b);
            state_d  = S_DONE;
          end else begin
            mop_d   = op3;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            lo_d    = f_abs(a, a_neg);
            opr_d   = f_abs(b, b_neg);
            hi_d    = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = f_finish(mop_q, neg_q, rneg_q, step_hi, step_lo);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opr_q    <= '0;
      mop_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opr_q    <= opr_d;
      mop_q    <= mop_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
endmodule

// File: tb/tb_alu_md_iter.sv
// Bench for alu_md_iter at XLEN=32 and XLEN=16 with a wide-integer reference model.
module tb_alu_md_iter;
  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_SLL = 5'h02, OP_SLT = 5'h03,
                         OP_SLTU = 5'h04, OP_XOR = 5'h05, OP_SRL = 5'h06, OP_SRA = 5'h07,
                         OP_OR = 5'h08, OP_AND = 5'h09, OP_PASSB = 5'h0A,
                         OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13,
                         OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_md_if #(.XLEN(32)) bus32 ();
  alu_md_if #(.XLEN(16)) bus16 ();

  alu_md_iter #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  alu_md_iter #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  // Architectural result for a w-bit unit, computed with 64-bit integers.
  function automatic logic [31:0] ref_model(input int w, input logic [4:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint mask, half, ua, ub, sa, sb, r;
    int     sh;
    half = longint'(1) << (w - 1);
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'h0, a}) & mask;
    ub   = longint'({32'h0, b}) & mask;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sh   = int'(ub & longint'(w - 1));
    case (op)
      OP_ADD:    r = ua + ub;
      OP_SUB:    r = ua - ub;
      OP_SLL:    r = ua << sh;
      OP_SLT:    r = (sa < sb) ? 64'sd1 : 64'sd0;
      OP_SLTU:   r = (ua < ub) ? 64'sd1 : 64'sd0;
      OP_XOR:    r = ua ^ ub;
      OP_SRL:    r = ua >> sh;
      OP_SRA:    r = sa >>> sh;
      OP_OR:     r = ua | ub;
      OP_AND:    r = ua & ub;
      OP_PASSB:  r = ub;
      OP_MUL:    r = sa * sb;
      OP_MULH:   r = (sa * sb) >>> w;
      OP_MULHSU: r = (sa * ub) >>> w;
      OP_MULHU:  r = (ua * ub) >> w;
      OP_DIV:    r = (ub == 0) ? -64'sd1 : (sa == -half && sb == -1) ? sa : sa / sb;
      OP_DIVU:   r = (ub == 0) ? -64'sd1 : ua / ub;
      OP_REM:    r = (ub == 0) ? ua : (sa == -half && sb == -1) ? 64'sd0 : sa % sb;
      OP_REMU:   r = (ub == 0) ? ua : ua % ub;
      default:   r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  // Cycles from accept to out_valid: 1 for base ops and divide corner cases, w+1 otherwise.
  function automatic int exp_lat(input int w, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    longint mask, half, ua, ub;
    half = longint'(1) << (w - 1);
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'h0, a}) & mask;
    ub   = longint'({32'h0, b}) & mask;
    if (!op[4]) return 1;
    if (op[2] && ub == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && ua == half && ub == mask) return 1;
    return w + 1;
  endfunction

  // Issue one request on the 32-bit unit and collect its result; lat=-1 on timeout.
  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    logic got;
    got = 1'b0;
    res = '0;
    lat = -1;
    @(negedge clk);
    bus32.op = op; bus32.data1 = a; bus32.data2 = b;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got = bus32.in_ready;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    #1 bus32.in_valid = 1'b0;
    if (!got) return;
    for (int i = 1; i <= 200; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (bus32.out_valid) begin lat = i; res = bus32.result; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat);
    logic got;
    got = 1'b0;
    res = '0;
    lat = -1;
    @(negedge clk);
    bus16.op = op; bus16.data1 = a; bus16.data2 = b;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got = bus16.in_ready;
      @(posedge clk);
      if (got) break;
      @(negedge clk);
    end
    #1 bus16.in_valid = 1'b0;
    if (!got) return;
    for (int i = 1; i <= 200; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (bus16.out_valid) begin lat = i; res = bus16.result; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.op = '0; bus32.data1 = '0; bus32.data2 = '0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.op = '0; bus16.data1 = '0; bus16.data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.result !== 32'h0) begin
      failures++;
      $display("FAIL reset32 out_valid=%b in_ready=%b result=%h want 0/1/00000000",
               bus32.out_valid, bus32.in_ready, bus32.result);
    end
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.result !== 16'h0) begin
      failures++;
      $display("FAIL reset16 out_valid=%b in_ready=%b result=%h want 0/1/0000",
               bus16.out_valid, bus16.in_ready, bus16.result);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", bus32.in_ready, bus32.out_valid);
    end
  endtask

  task automatic test_add_overflow();
    logic [31:0] res;
    int          lat;
    run32(OP_ADD, 32'h7FFF_FFFF, 32'h1, res, lat);
    checks++;
    if (res !== 32'h8000_0000 || lat !== 1) begin
      failures++;
      $display("FAIL add_ovf got=%h lat=%0d want=80000000 lat=1", res, lat);
    end
    checks++;
    if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_ready_return in_ready=%b out_valid=%b want 1/0", bus32.in_ready, bus32.out_valid);
    end
  endtask

  task automatic test_directed32();
    vec_t        tv [16];
    logic [31:0] res;
    int          lat;
    tv = '{
      '{OP_SRA,    32'h8000_0000, 32'd33,        32'hC000_0000, 1},
      '{OP_SLL,    32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1},
      '{OP_MULH,   32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33},
      '{OP_MUL,    32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 33},
      '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
      '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
      '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
      '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
      '{OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1},
      '{OP_REM,    32'd5,         32'd0,         32'd5,         1},
      '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1},
      '{OP_REMU,   32'd100,       32'd7,         32'd2,         33},
      '{OP_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1,         1},
      '{OP_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0,         1},
      '{5'h0B,     32'h0000_FFFF, 32'h0000_FFFF, 32'd0,         1}
    };
    foreach (tv[i]) begin
      run32(tv[i].op, tv[i].a, tv[i].b, res, lat);
      checks++;
      if (res !== tv[i].e || lat !== tv[i].lat) begin
        failures++;
        $display("FAIL directed32[%0d] op=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, tv[i].op, tv[i].a, tv[i].b, res, lat, tv[i].e, tv[i].lat);
      end
    end
  endtask

  task automatic test_random_base();
    logic [31:0] res, a, b, e;
    logic [4:0]  op;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = b & 32'hFFFF_FFE7;
      e  = ref_model(32, op, a, b);
      run32(op, a, b, res, lat);
      checks++;
      if (res !== e || lat !== 1) begin
        failures++;
        $display("FAIL rand_base[%0d] op=%h a=%h b=%h got=%h lat=%0d want=%h lat=1",
                 i, op, a, b, res, lat, e);
      end
    end
  endtask

  task automatic test_random_md();
    logic [31:0] res, a, b, e;
    logic [4:0]  op;
    int          lat, el;
    for (int i = 0; i < 40; i++) begin
      op = 5'h10 | 5'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      e  = ref_model(32, op, a, b);
      el = exp_lat(32, op, a, b);
      run32(op, a, b, res, lat);
      checks++;
      if (res !== e || lat !== el) begin
        failures++;
        $display("FAIL rand_md[%0d] op=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, op, a, b, res, lat, e, el);
      end
    end
  endtask

  task automatic test_backpressure();
    logic got;
    int   waited;
    @(negedge clk);
    bus32.op = OP_DIVU; bus32.data1 = 32'd100; bus32.data2 = 32'd7;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b0;
    got = bus32.in_ready;
    @(posedge clk);
    #1;
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept in_ready=%b want 1", got);
    end
    // A second request is held on the bus while the divide is busy.
    bus32.op = OP_ADD; bus32.data1 = 32'd40; bus32.data2 = 32'd2;
    waited = 0;
    while (bus32.out_valid !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (waited !== 32) begin
      failures++;
      $display("FAIL bp_latency got=%0d extra cycles want 32", waited);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.result !== 32'd14 || bus32.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] out_valid=%b result=%h in_ready=%b want 1/0000000e/0",
                 i, bus32.out_valid, bus32.result, bus32.in_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk) bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", bus32.out_valid, bus32.in_ready);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.result !== 32'd42) begin
      failures++;
      $display("FAIL bp_next_req out_valid=%b result=%h want 1/0000002a", bus32.out_valid, bus32.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int          lat, stray;
    @(negedge clk);
    bus32.op = OP_MULHU; bus32.data1 = 32'hFFFF_FFFF; bus32.data2 = 32'hFFFF_FFFF;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.result !== 32'h0) begin
      failures++;
      $display("FAIL abort_async out_valid=%b in_ready=%b result=%h want 0/1/00000000",
               bus32.out_valid, bus32.in_ready, bus32.result);
    end
    @(negedge clk) rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL abort_stale out_valid high %0d cycles want 0", stray);
    end
    run32(OP_ADD, 32'd2, 32'd3, res, lat);
    checks++;
    if (res !== 32'd5 || lat !== 1) begin
      failures++;
      $display("FAIL abort_next_add got=%h lat=%0d want=00000005 lat=1", res, lat);
    end
  endtask

  task automatic test_xlen16();
    vec_t        tv [9];
    logic [15:0] res, a, b;
    logic [31:0] e;
    logic [4:0]  op;
    int          lat, el;
    tv = '{
      '{OP_MULH,  32'hFFFE, 32'd3,    32'hFFFF, 17},
      '{OP_MUL,   32'hFFFE, 32'd3,    32'hFFFA, 17},
      '{OP_MULHU, 32'hFFFF, 32'hFFFF, 32'hFFFE, 17},
      '{OP_DIV,   32'hFFF9, 32'd2,    32'hFFFD, 17},
      '{OP_REM,   32'hFFF9, 32'd2,    32'hFFFF, 17},
      '{OP_DIVU,  32'h1234, 32'd0,    32'hFFFF, 1},
      '{OP_REM,   32'd5,    32'd0,    32'd5,    1},
      '{OP_DIV,   32'h8000, 32'hFFFF, 32'h8000, 1},
      '{OP_DIVU,  32'd100,  32'd7,    32'd14,   17}
    };
    foreach (tv[i]) begin
      run16(tv[i].op, tv[i].a[15:0], tv[i].b[15:0], res, lat);
      checks++;
      if (res !== tv[i].e[15:0] || lat !== tv[i].lat) begin
        failures++;
        $display("FAIL directed16[%0d] op=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, tv[i].op, tv[i].a[15:0], tv[i].b[15:0], res, lat, tv[i].e[15:0], tv[i].lat);
      end
    end
    for (int i = 0; i < 30; i++) begin
      op = (i % 3 == 0) ? 5'($urandom_range(0, 15)) : (5'h10 | 5'($urandom_range(0, 7)));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i % 7 == 0) b = 16'h0;
      e  = ref_model(16, op, {16'h0, a}, {16'h0, b});
      el = exp_lat(16, op, {16'h0, a}, {16'h0, b});
      run16(op, a, b, res, lat);
      checks++;
      if (res !== e[15:0] || lat !== el) begin
        failures++;
        $display("FAIL rand16[%0d] op=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, op, a, b, res, lat, e[15:0], el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_directed32();
    test_random_base();
    test_random_md();
    test_backpressure();
    test_reset_abort();
    test_xlen16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
